adc_sdo_responder: RTL

ADC_SDO_RESPONDER -- requirements
Module: adc_sdo_responder

---
 rtl/adc_sdo_responder_if.sv | 16 +
 rtl/adc_sdo_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/adc_sdo_responder_if.sv
// ---------------------------------------------------------------------------
// adc_sdo_responder_if
//   Serial readout bus between an ADC initiator and the responder model.
//   adc_convert : conversion strobe, initiator -> responder
//   adc_sck     : serial clock,      initiator -> responder
//   adc_sdo     : serial data,       responder -> initiator, MSB first
//   All three signals live in the single system clock domain.
// ---------------------------------------------------------------------------
interface adc_sdo_responder_if;
  logic adc_convert;
  logic adc_sck;
  logic adc_sdo;

  modport master (output adc_convert, output adc_sck, input adc_sdo);
  modport slave  (input adc_convert, input adc_sck, output adc_sdo);
endinterface

// File: rtl/adc_sdo_responder.sv
// ---------------------------------------------------------------------------
// adc_sdo_responder
//   Behavioural responder for a convert/SCK/SDO style serial ADC. A rising
//   convert starts a conversion lasting CONV_CYCLES clocks; the falling edge
//   of convert starts the readout, which shifts the result out MSB first,
//   one bit per rising SCK edge.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous, active-high reset
//   adc          : serial bus (slave side): adc_convert, adc_sck in; adc_sdo out
//   sample_in    : live sample value, used when pattern_sel = 00
//   pattern_sel  : 00 sample_in, 01 ramp, 10 constant 0x2AAA, 11 all-ones
//   busy         : high whenever the FSM is not idle
//   frame_done   : one-cycle pulse per completed readout
//   early_err    : one-cycle pulse when convert falls mid-conversion
//   frame_count  : number of completed readouts, wraps at 16 bits
// ---------------------------------------------------------------------------
module adc_sdo_responder #(
  parameter int DATA_BITS   = 14,
  parameter int CONV_CYCLES = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_sdo_responder_if.slave   adc,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic [1:0]           pattern_sel,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 early_err,
  output logic [15:0]          frame_count
);

  localparam int TW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0]        CONV_LAST = TW'(CONV_CYCLES - 1);
  localparam logic [IW-1:0]        IDX_TOP   = IW'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] PAT_AAA   = DATA_BITS'(32'h0000_2AAA);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_READY,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic                 conv_q, sck_q;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] ramp;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shreg;
  logic                 err_q;

  // Edge detection against the previous-cycle copy of each strobe.
  logic conv_rise, conv_fall, sck_rise, sck_act;
  assign conv_rise = adc.adc_convert & ~conv_q;
  assign conv_fall = ~adc.adc_convert & conv_q;
  assign sck_rise  = adc.adc_sck & ~sck_q;
  // A convert edge in the same cycle wins; the SCK edge is dropped.
  assign sck_act   = sck_rise & ~(conv_rise | conv_fall);

  // Conversion bookkeeping decoded from the current state.
  logic timer_exp, do_latch, do_early;
  assign timer_exp = (timer == CONV_LAST);
  assign do_latch  = (state == S_CONV) & timer_exp;
  assign do_early  = (state == S_CONV) & ~timer_exp & conv_fall;

  // Source selected at latch time only.
  logic [DATA_BITS-1:0] src;
  always_comb begin
    src = '0;
    unique case (pattern_sel)
      2'b00:   src = sample_in;
      2'b01:   src = ramp;
      2'b10:   src = PAT_AAA;
      default: src = '1;
    endcase
  end

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (conv_rise) state_nxt = S_CONV;
      S_CONV: begin
        // A fall landing exactly on expiry still yields a fresh result, and
        // must go straight to SHIFT since the edge will not be seen again.
        if (timer_exp)      state_nxt = conv_fall ? S_SHIFT : S_READY;
        else if (conv_fall) state_nxt = S_SHIFT;
      end
      S_READY: if (conv_fall) state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (conv_rise)                   state_nxt = S_CONV;
        else if (sck_act && idx == '0)   state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = conv_rise ? S_CONV : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- outputs
  always_comb begin
    busy        = (state != S_IDLE);
    frame_done  = (state == S_DONE);
    early_err   = err_q;
    adc.adc_sdo = 1'b0;
    unique case (state)
      S_READY: adc.adc_sdo = shreg[DATA_BITS-1];
      S_SHIFT: adc.adc_sdo = shreg[idx];
      default: adc.adc_sdo = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_q      <= 1'b0;
      sck_q       <= 1'b0;
      timer       <= '0;
      idx         <= '0;
      ramp        <= '0;
      hold        <= '0;
      shreg       <= '0;
      err_q       <= 1'b0;
      frame_count <= '0;
    end else begin
      conv_q <= adc.adc_convert;
      sck_q  <= adc.adc_sck;
      err_q  <= do_early;

      unique case (state)
        S_IDLE: begin
          if (conv_rise) timer <= '0;
        end
        S_CONV: begin
          if (do_latch) begin
            hold  <= src;
            shreg <= src;
            ramp  <= ramp + DATA_BITS'(1);
            idx   <= IDX_TOP;
          end else begin
            timer <= timer + TW'(1);
            // Early fall: replay the previous result instead.
            if (do_early) begin
              shreg <= hold;
              idx   <= IDX_TOP;
            end
          end
        end
        S_READY: begin
          if (conv_fall) idx <= IDX_TOP;
        end
        S_SHIFT: begin
          if (conv_rise)                  timer <= '0;
          else if (sck_act && idx != '0)  idx   <= idx - IW'(1);
        end
        S_DONE: begin
          frame_count <= frame_count + 16'd1;
          if (conv_rise) timer <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
